// File: rtl/counter_frame_reader_pkg.sv
// Shared constants, field layout and state encoding for the counter frame reader.
// Optional statistics outputs in the top are selected with FRAME_STATS_EN.
package counter_frame_reader_pkg;

    localparam logic [7:0] EVENT_HEADER_BYTE = 8'hAA;
    localparam logic [7:0] DATA_HEADER_BYTE  = 8'hDD;
    localparam int         FRAME_BYTES       = 32;

    // Byte offsets of each little-endian field inside a frame
    localparam int PPS_OFS     = 2;
    localparam int TENMHZ_OFS  = 4;
    localparam int EVENT_OFS   = 8;
    localparam int TRIG_OFS    = 12;
    localparam int CLOCK_OFS   = 16;
    localparam int TRAILER_OFS = 24;

    localparam int FIELD_BITS = (TRAILER_OFS - PPS_OFS) * 8;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TRAILER = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/counter_frame_reader.sv
// Drains the counter FIFO, re-syncs on the 0xAA 0xAA header, checks the 0xDD trailer
// and presents one counter record per frame. Define FRAME_STATS_EN for STAT_GOOD/STAT_ERR.
module counter_frame_reader
    import counter_frame_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FRAME_BYTES    = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  CFIFO_DOUT,
    input  logic        CFIFO_VALID,
    input  logic        CFIFO_EMPTY,
    output logic        CFIFO_RDEN,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [15:0] EVT_PPS,
    output logic [31:0] EVT_TENMHZ,
    output logic [31:0] EVT_EVENT,
    output logic [31:0] EVT_TRIG,
    output logic [63:0] EVT_CLOCK,
    output logic        FRAME_ERR,
    output logic [1:0]  FRAME_ERR_CODE,
`ifdef FRAME_STATS_EN
    output logic [31:0] STAT_GOOD,
    output logic [31:0] STAT_ERR,
`endif
    output state_t      DBG_STATE
);

    // Handshake: a record transfers on a cycle where EVT_VALID and EVT_READY are both
    // high; while EVT_VALID is high the EVT_* fields never change and EVT_VALID only
    // drops after that transfer.

    localparam int CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam int TEN_LSB   = (TENMHZ_OFS - PPS_OFS) * 8;
    localparam int EVENT_LSB = (EVENT_OFS  - PPS_OFS) * 8;
    localparam int TRIG_LSB  = (TRIG_OFS   - PPS_OFS) * 8;
    localparam int CLOCK_LSB = (CLOCK_OFS  - PPS_OFS) * 8;

    state_t                state_q;
    state_t                state_d;
    logic                  run_q;
    logic                  outstanding_q;
    logic [7:0]            prev_q;
    logic [CNT_W-1:0]      rd_cnt_q;
    logic [CNT_W-1:0]      byte_idx_q;
    logic [CNT_W-1:0]      field_sel;
    logic [IDLE_W-1:0]     idle_q;
    logic                  mismatch_q;
    logic [FIELD_BITS-1:0] fields_q;
    logic                  err_q;
    logic [1:0]            code_q;

    logic hdr_hit;
    logic last_byte;
    logic timeout;
    logic rden;

    assign hdr_hit   = (state_q == HUNT) && CFIFO_VALID &&
                       (prev_q == EVENT_HEADER_BYTE) && (CFIFO_DOUT == EVENT_HEADER_BYTE);
    assign last_byte = (state_q == COLLECT) && CFIFO_VALID &&
                       (byte_idx_q == CNT_W'(FRAME_BYTES - 1));
    assign timeout   = (state_q == COLLECT) && !CFIFO_VALID &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign field_sel = byte_idx_q - CNT_W'(PPS_OFS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rden    = 1'b0;
        case (state_q)
            HUNT: begin
                // One read in flight, except the header hit which starts the frame pipeline
                if (run_q && !CFIFO_EMPTY && (!outstanding_q || hdr_hit)) begin
                    rden = 1'b1;
                end
                if (hdr_hit) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!CFIFO_EMPTY && (rd_cnt_q < CNT_W'(FRAME_BYTES))) begin
                    rden = 1'b1;
                end
                if (last_byte) begin
                    state_d = CHECK;
                end else if (timeout) begin
                    state_d = HUNT;
                end
            end
            CHECK: begin
                state_d = mismatch_q ? HUNT : HOLD;
            end
            HOLD: begin
                if (EVT_READY) begin
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_q         <= 1'b0;
            outstanding_q <= 1'b0;
            prev_q        <= 8'h00;
            rd_cnt_q      <= '0;
            byte_idx_q    <= '0;
            idle_q        <= '0;
            mismatch_q    <= 1'b0;
            fields_q      <= '0;
            err_q         <= 1'b0;
            code_q        <= ERR_NONE;
        end else begin
            run_q <= 1'b1;
            err_q <= 1'b0;

            if (rden) begin
                outstanding_q <= 1'b1;
            end else if (CFIFO_VALID) begin
                outstanding_q <= 1'b0;
            end

            if (CFIFO_VALID || (state_q != COLLECT)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end

            case (state_q)
                HUNT: begin
                    if (CFIFO_VALID) begin
                        prev_q <= hdr_hit ? 8'h00 : CFIFO_DOUT;
                    end
                    if (hdr_hit) begin
                        byte_idx_q <= CNT_W'(PPS_OFS);
                        rd_cnt_q   <= rden ? CNT_W'(PPS_OFS + 1) : CNT_W'(PPS_OFS);
                        mismatch_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    prev_q <= 8'h00;
                    if (rden) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if (CFIFO_VALID) begin
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q < CNT_W'(TRAILER_OFS)) begin
                            fields_q[{field_sel, 3'b000} +: 8] <= CFIFO_DOUT;
                        end else if (CFIFO_DOUT != DATA_HEADER_BYTE) begin
                            mismatch_q <= 1'b1;
                        end
                    end
                    if (timeout) begin
                        err_q         <= 1'b1;
                        code_q        <= ERR_TIMEOUT;
                        outstanding_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (mismatch_q) begin
                        err_q  <= 1'b1;
                        code_q <= ERR_TRAILER;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STAT_GOOD <= '0;
            STAT_ERR  <= '0;
        end else begin
            if ((state_q == HOLD) && EVT_READY) begin
                STAT_GOOD <= STAT_GOOD + 32'd1;
            end
            if (err_q) begin
                STAT_ERR <= STAT_ERR + 32'd1;
            end
        end
    end
`endif

    assign CFIFO_RDEN     = rden;
    assign EVT_VALID      = (state_q == HOLD);
    assign EVT_PPS        = fields_q[TEN_LSB-1:0];
    assign EVT_TENMHZ     = fields_q[EVENT_LSB-1:TEN_LSB];
    assign EVT_EVENT      = fields_q[TRIG_LSB-1:EVENT_LSB];
    assign EVT_TRIG       = fields_q[CLOCK_LSB-1:TRIG_LSB];
    assign EVT_CLOCK      = fields_q[FIELD_BITS-1:CLOCK_LSB];
    assign FRAME_ERR      = err_q;
    assign FRAME_ERR_CODE = code_q;
    assign DBG_STATE      = state_q;

endmodule
